// File: rtl/switch_allocator_pkg.sv
// Shared NoC router parameters and types for the switch allocation stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package switch_allocator_pkg;

    localparam int VC_NUM    = 2;
    localparam int PORT_NUM  = 5;
    localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    // Index order matters: crossbar selects and arbiter priority use it.
    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/switch_allocator_if.sv
// Bundle between the input ports / downstream flags and the switch allocator.
// Latency: n/a; read handshake is combinational, crossbar fields are registered.
// Backpressure: on_off gates eligibility per downstream VC.
// master = input-port side, slave = allocator.
interface switch_allocator_if;
    import switch_allocator_pkg::*;

    logic  [PORT_NUM-1:0][VC_NUM-1:0]              request;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off;
    logic  [PORT_NUM-1:0]                          valid_sel;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0]           xb_sel;
    logic  [PORT_NUM-1:0]                          valid_flit;

    modport master (
        output request, out_port, downstream_vc, on_off,
        input  valid_sel, vc_sel, xb_sel, valid_flit
    );

    modport slave (
        input  request, out_port, downstream_vc, on_off,
        output valid_sel, vc_sel, xb_sel, valid_flit
    );

endinterface

// File: rtl/switch_allocator_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, pointer moves past the grantee.
// Latency: 0 cycles request->grant; pointer updates on the next clk edge.
// Backpressure: update_i=0 holds priority so a blocked grantee keeps its turn.
// Ports: clk, rst, request_i[N], update_i, grant_o[N] (one-hot), grant_idx_o.
module round_robin_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     request_i,
    input  logic             update_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin : search
        int   j;
        logic found;
        j           = 0;
        found       = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        // Scan from the pointer upward, wrapping; first requester wins.
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!found && request_i[j]) begin
                found       = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = IDX_W'(j);
            end
        end
        ptr_d = ptr_q;
        if (update_i && found) begin
            ptr_d = (int'(grant_idx_o) == N - 1) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator with round-robin at both stages.
// Latency: valid_sel/vc_sel same cycle as request; xb_sel/valid_flit one cycle later.
// Backpressure: requests to a downstream VC with on_off=0 are never granted.
// Ports: clk, rst (sync, active-high), sa_if (slave): per-VC request/route/
// downstream VC/on_off in; valid_sel, vc_sel, xb_sel, valid_flit out.
module switch_allocator
    import switch_allocator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    switch_allocator_if.slave  sa_if
);

    logic [PORT_NUM-1:0][VC_NUM-1:0]    elig;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    s1_gnt;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   cand_vc;
    logic [PORT_NUM-1:0]                cand_valid;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  out_req;   // [output][input]
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  s2_gnt;    // [output][input]
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] s2_idx;
    logic [PORT_NUM-1:0]                out_vld;
    logic [PORT_NUM-1:0]                in_win;
    logic [PORT_NUM-1:0]                valid_flit_q, valid_flit_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel_q, xb_sel_d;

    // A VC competes only if its allocated downstream VC is currently on.
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (int'(sa_if.out_port[i][v]) < PORT_NUM) begin
                    elig[i][v] = sa_if.request[i][v] &
                        sa_if.on_off[sa_if.out_port[i][v]][sa_if.downstream_vc[i][v]];
                end
            end
        end
    end

    // Stage 1 pointer only advances when the input also wins stage 2.
    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in_arb
        round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
            .clk         (clk),
            .rst         (rst),
            .request_i   (elig[i]),
            .update_i    (in_win[i]),
            .grant_o     (s1_gnt[i]),
            .grant_idx_o (cand_vc[i])
        );
    end

    always_comb begin
        cand_valid = '0;
        out_req    = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            cand_valid[i] = |s1_gnt[i];
            for (int o = 0; o < PORT_NUM; o++) begin
                out_req[o][i] = cand_valid[i] &&
                                (int'(sa_if.out_port[i][cand_vc[i]]) == o);
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out_arb
        round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
            .clk         (clk),
            .rst         (rst),
            .request_i   (out_req[o]),
            .update_i    (out_vld[o]),
            .grant_o     (s2_gnt[o]),
            .grant_idx_o (s2_idx[o])
        );
    end

    always_comb begin
        in_win       = '0;
        out_vld      = '0;
        valid_flit_d = '0;
        xb_sel_d     = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            out_vld[o] = |s2_gnt[o];
            in_win     = in_win | s2_gnt[o];
            if (out_vld[o] && !rst) begin
                valid_flit_d[o] = 1'b1;
                xb_sel_d[o]     = s2_idx[o];
            end
        end
    end

    // Read handshake back to the input ports; muted while in reset.
    always_comb begin
        sa_if.valid_sel = '0;
        sa_if.vc_sel    = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (in_win[i] && !rst) begin
                sa_if.valid_sel[i] = 1'b1;
                sa_if.vc_sel[i]    = cand_vc[i];
            end
        end
    end

    // Registered so the crossbar lines up with the buffer read one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_flit_q <= '0;
            xb_sel_q     <= '0;
        end else begin
            valid_flit_q <= valid_flit_d;
            xb_sel_q     <= xb_sel_d;
        end
    end

    assign sa_if.valid_flit = valid_flit_q;
    assign sa_if.xb_sel     = xb_sel_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator.
// Latency: checks combinational read handshake and one-cycle crossbar outputs.
// Backpressure: exercises on_off gating of eligibility.
module tb_switch_allocator;
    import switch_allocator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    switch_allocator_if sa_if ();

    switch_allocator dut (
        .clk   (clk),
        .rst   (rst),
        .sa_if (sa_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sa_if.request       = '0;
        sa_if.downstream_vc = '0;
        sa_if.on_off        = '0;
        for (int i = 0; i < PORT_NUM; i++)
            for (int v = 0; v < VC_NUM; v++)
                sa_if.out_port[i][v] = LOCAL;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        sa_if.request[0][0]  = 1'b1;
        sa_if.out_port[0][0] = NORTH;
        sa_if.on_off[1][0]   = 1'b1;
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b00000) begin
            errors++;
            $display("FAIL reset_valid_sel got %b expected %b", sa_if.valid_sel, 5'b00000);
        end
        tick();
        checks++;
        if (sa_if.valid_flit !== 5'b00000) begin
            errors++;
            $display("FAIL reset_valid_flit got %b expected %b", sa_if.valid_flit, 5'b00000);
        end
        checks++;
        if (sa_if.xb_sel !== 15'd0) begin
            errors++;
            $display("FAIL reset_xb_sel got %h expected %h", sa_if.xb_sel, 15'd0);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        sa_if.request[1][1]       = 1'b1;
        sa_if.out_port[1][1]      = EAST;
        sa_if.downstream_vc[1][1] = 1'b0;
        sa_if.on_off[4][0]        = 1'b1;
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b00010) begin
            errors++;
            $display("FAIL single_valid_sel got %b expected %b", sa_if.valid_sel, 5'b00010);
        end
        checks++;
        if (sa_if.vc_sel[1] !== 1'b1) begin
            errors++;
            $display("FAIL single_vc_sel got %0d expected 1", sa_if.vc_sel[1]);
        end
        tick();
        checks++;
        if (sa_if.valid_flit !== 5'b10000) begin
            errors++;
            $display("FAIL single_valid_flit got %b expected %b", sa_if.valid_flit, 5'b10000);
        end
        checks++;
        if (sa_if.xb_sel[4] !== 3'd1) begin
            errors++;
            $display("FAIL single_xb_sel got %0d expected 1", sa_if.xb_sel[4]);
        end
        clear_inputs();
    endtask

    task automatic test_out_fairness();
        int         exp_in [4] = '{2, 3, 2, 3};
        logic [4:0] expv;
        do_reset();
        sa_if.request[2][0]  = 1'b1;
        sa_if.request[3][0]  = 1'b1;
        sa_if.out_port[2][0] = LOCAL;
        sa_if.out_port[3][0] = LOCAL;
        sa_if.on_off[0][0]   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expv = 5'b00001 << exp_in[k];
            #1;
            checks++;
            if (sa_if.valid_sel !== expv) begin
                errors++;
                $display("FAIL out_fair_valid_sel[%0d] got %b expected %b", k, sa_if.valid_sel, expv);
            end
            tick();
            checks++;
            if (sa_if.valid_flit[0] !== 1'b1 || sa_if.xb_sel[0] !== 3'(exp_in[k])) begin
                errors++;
                $display("FAIL out_fair_xb_sel[%0d] got vld=%b sel=%0d expected vld=1 sel=%0d",
                         k, sa_if.valid_flit[0], sa_if.xb_sel[0], exp_in[k]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_vc_fairness();
        logic exp_vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        sa_if.request[0]     = 2'b11;
        sa_if.out_port[0][0] = NORTH;
        sa_if.out_port[0][1] = SOUTH;
        sa_if.on_off[1][0]   = 1'b1;
        sa_if.on_off[2][0]   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (sa_if.valid_sel[0] !== 1'b1 || sa_if.vc_sel[0] !== exp_vc[k]) begin
                errors++;
                $display("FAIL vc_fair[%0d] got vld=%b vc=%0d expected vld=1 vc=%0d",
                         k, sa_if.valid_sel[0], sa_if.vc_sel[0], exp_vc[k]);
            end
            tick();
        end
        // SOUTH input now outranks LOCAL on the NORTH output.
        sa_if.request[2][0]  = 1'b1;
        sa_if.out_port[2][0] = NORTH;
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b00100 || sa_if.vc_sel[0] !== 1'b0) begin
            errors++;
            $display("FAIL vc_stage2_loss got vld=%b vc0=%0d expected vld=00100 vc0=0",
                     sa_if.valid_sel, sa_if.vc_sel[0]);
        end
        tick();
        sa_if.request[2][0] = 1'b0;
        #1;
        checks++;
        if (sa_if.valid_sel[0] !== 1'b1 || sa_if.vc_sel[0] !== 1'b0) begin
            errors++;
            $display("FAIL vc_ptr_hold got vld=%b vc=%0d expected vld=1 vc=0",
                     sa_if.valid_sel[0], sa_if.vc_sel[0]);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_flow_control();
        do_reset();
        sa_if.request[0][0]       = 1'b1;
        sa_if.out_port[0][0]      = EAST;
        sa_if.downstream_vc[0][0] = 1'b1;
        sa_if.on_off[4][1]        = 1'b0;
        sa_if.on_off[4][0]        = 1'b1;
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b00000) begin
            errors++;
            $display("FAIL fc_off_valid_sel got %b expected %b", sa_if.valid_sel, 5'b00000);
        end
        tick();
        checks++;
        if (sa_if.valid_flit !== 5'b00000) begin
            errors++;
            $display("FAIL fc_off_valid_flit got %b expected %b", sa_if.valid_flit, 5'b00000);
        end
        sa_if.on_off[4][1] = 1'b1;
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b00001) begin
            errors++;
            $display("FAIL fc_on_valid_sel got %b expected %b", sa_if.valid_sel, 5'b00001);
        end
        tick();
        checks++;
        if (sa_if.valid_flit !== 5'b10000 || sa_if.xb_sel[4] !== 3'd0) begin
            errors++;
            $display("FAIL fc_on_flit got vld=%b sel=%0d expected vld=10000 sel=0",
                     sa_if.valid_flit, sa_if.xb_sel[4]);
        end
        clear_inputs();
    endtask

    task automatic test_permutation();
        do_reset();
        for (int i = 0; i < PORT_NUM; i++) begin
            sa_if.request[i][0]  = 1'b1;
            sa_if.out_port[i][0] = port_t'((i + 1) % PORT_NUM);
            sa_if.on_off[i][0]   = 1'b1;
        end
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b11111) begin
            errors++;
            $display("FAIL perm_valid_sel got %b expected %b", sa_if.valid_sel, 5'b11111);
        end
        tick();
        checks++;
        if (sa_if.valid_flit !== 5'b11111) begin
            errors++;
            $display("FAIL perm_valid_flit got %b expected %b", sa_if.valid_flit, 5'b11111);
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            checks++;
            if (sa_if.xb_sel[o] !== 3'((o + PORT_NUM - 1) % PORT_NUM)) begin
                errors++;
                $display("FAIL perm_xb_sel[%0d] got %0d expected %0d",
                         o, sa_if.xb_sel[o], (o + PORT_NUM - 1) % PORT_NUM);
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_traffic();
        do_reset();
        for (int i = 0; i < PORT_NUM; i++) begin
            sa_if.request[i][0]  = 1'b1;
            sa_if.out_port[i][0] = LOCAL;
        end
        sa_if.on_off[0][0] = 1'b1;
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b00001) begin
            errors++;
            $display("FAIL mid_first_grant got %b expected %b", sa_if.valid_sel, 5'b00001);
        end
        tick();
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b00010) begin
            errors++;
            $display("FAIL mid_second_grant got %b expected %b", sa_if.valid_sel, 5'b00010);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b00000) begin
            errors++;
            $display("FAIL mid_rst_valid_sel got %b expected %b", sa_if.valid_sel, 5'b00000);
        end
        tick();
        checks++;
        if (sa_if.valid_flit !== 5'b00000) begin
            errors++;
            $display("FAIL mid_rst_valid_flit got %b expected %b", sa_if.valid_flit, 5'b00000);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (sa_if.valid_sel !== 5'b00001) begin
            errors++;
            $display("FAIL mid_restart_grant got %b expected %b", sa_if.valid_sel, 5'b00001);
        end
        tick();
        checks++;
        if (sa_if.valid_flit[0] !== 1'b1 || sa_if.xb_sel[0] !== 3'd0) begin
            errors++;
            $display("FAIL mid_restart_xb got vld=%b sel=%0d expected vld=1 sel=0",
                     sa_if.valid_flit[0], sa_if.xb_sel[0]);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        tick();
        test_reset();
        test_single();
        test_out_fairness();
        test_vc_fairness();
        test_flow_control();
        test_permutation();
        test_reset_mid_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Router-level switch allocation (SA) stage, directly downstream of every input port.
- Consumes each input port's per-VC request, route and allocated downstream VC, plus the downstream on/off flags per output port.
- Returns the per-input read handshake to each input port (vc_sel/valid_sel) and, one cycle later, the crossbar select and output valid for switch traversal.
- Separable input-first allocator with round-robin fairness at both stages.

Parameters:
- VC_NUM, noc_params::VC_NUM, virtual channels per port.
- PORT_NUM, noc_params::PORT_NUM, router ports (5: LOCAL, NORTH, SOUTH, WEST, EAST).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- request_i  input  [PORT_NUM][VC_NUM]  input VC holds a flit and owns an allocated downstream VC.
- out_port_i  input  port_t [PORT_NUM][VC_NUM]  output port routed for each input VC.
- downstream_vc_i  input  [PORT_NUM][VC_NUM] x VC_SIZE  downstream VC allocated to each input VC.
- on_off_i  input  [PORT_NUM][VC_NUM]  1 = downstream VC v on output port p accepts flits.
- valid_sel_o  output  [PORT_NUM]  read strobe to input port p (combinational).
- vc_sel_o  output  [PORT_NUM] x VC_SIZE  VC index read at input port p (combinational).
- xb_sel_o  output  [PORT_NUM] x PORT_SIZE  crossbar: input port driving output p (registered).
- valid_flit_o  output  [PORT_NUM]  output p carries a valid flit this cycle (registered).

Behaviour:
- Eligibility: elig[i][v] = request_i[i][v] AND on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]].
- Stage 1, per input i: round-robin arbiter over elig[i][*] with pointer in_ptr[i]. Produces candidate VC cand_vc[i] and cand_valid[i].
- Stage 2, per output o: round-robin arbiter over inputs i with cand_valid[i] AND out_port_i[i][cand_vc[i]] == o, using pointer out_ptr[o].
- Round-robin priority: search starts at the pointer index and wraps modulo N. After a grant, the pointer is set to granted index + 1, wrapping N-1 -> 0.
- Grant: input i wins iff it is granted in stage 2.
  - valid_sel_o[i] = 1 and vc_sel_o[i] = cand_vc[i], in the same cycle as the request (SA latency 0).
  - A losing input drives valid_sel_o[i] = 0 and vc_sel_o[i] = 0.
- Pointer update on rising clk, only for winners:
  - in_ptr[i] advances only if input i won stage 2. A stage-1 winner that loses stage 2 keeps its pointer.
  - out_ptr[o] advances only if output o granted someone.
- ST stage registers, loaded each cycle: valid_flit_o[o] <= output o granted; xb_sel_o[o] <= granted input index, else 0.
  - This aligns with the input-port buffer read, whose flit appears on flit_o one cycle after valid_sel.
- Guarantees:
  - At most one valid_sel per input and one grant per output per cycle.
  - No grant to an off downstream VC.
  - A persistent eligible requester is served within VC_NUM*PORT_NUM grants of its output.
- Reset (rst = 1 at a clk edge, including mid-traffic):
  - All in_ptr and out_ptr = 0.
  - valid_flit_o = 0, xb_sel_o = 0.
  - Combinational valid_sel_o is forced to 0 while rst = 1.
- No requests: all outputs idle and pointers hold.
- on_off_i dropping in the same cycle as a request: the request is not eligible and no grant is issued.

Decomposition:
- noc_params additions: PORT_SIZE = $clog2(PORT_NUM). port_t, VC_NUM, VC_SIZE and PORT_NUM already live there.
- Sub-module round_robin_arbiter #(N):
  - Ports: clk, rst, request_i[N], update_i, grant_o[N] one-hot, grant_idx_o.
  - Holds its own pointer; the pointer moves only when update_i = 1.
  - Instantiated PORT_NUM times for stage 1 (N = VC_NUM) and PORT_NUM times for stage 2 (N = PORT_NUM).

Test Plan:
- Single request: input NORTH, VC1, routed EAST, downstream VC0 on.
  -> Same cycle: valid_sel_o[NORTH] = 1, vc_sel_o[NORTH] = 1.
  -> Next cycle: valid_flit_o[EAST] = 1, xb_sel_o[EAST] = NORTH.
- Fairness on one output: WEST VC0 and SOUTH VC0 both target LOCAL, held for 4 cycles, starting after reset.
  -> Grants alternate SOUTH, WEST, SOUTH, WEST (index order LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4).
- VC fairness: LOCAL VC0 and VC1 target distinct outputs, held for 4 cycles.
  -> vc_sel_o[LOCAL] = 0, 1, 0, 1.
  -> A stage-2 loss in between does not advance in_ptr.
- Flow control: the only request targets a downstream VC with on_off = 0.
  -> No valid_sel and no valid_flit.
  -> Setting on_off = 1 produces a grant in that same cycle.
- Full permutation: 5 inputs to 5 distinct outputs.
  -> All 5 valid_sel_o high in one cycle.
  -> Next cycle: all valid_flit_o high with matching xb_sel_o.
- Reset mid-traffic: assert rst during a saturated pattern.
  -> Same cycle: valid_sel_o = 0.
  -> Next edge: valid_flit_o = 0.
  -> After release, arbitration restarts from index 0.
